// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Merges arithmetic-unit and multicycle-unit results onto the
//            single register-file write port. AU results cannot be stalled,
//            so they always win. MU results are buffered in a small FIFO and
//            drained in cycles the AU leaves idle. A result goes straight
//            through when the FIFO is empty and the AU is idle.
// Ports    : CLK, nRST        - clock, asynchronous active-low reset
//            wen_au/reg_rd_au/wdata_au - AU result triple (no back-pressure)
//            mu_valid/mu_rd/mu_wdata   - MU result triple
//            mu_ready         - buffer can accept an MU result this cycle
//            rf_wen/rf_rd/rf_wdata     - registered register-file write port
//            stall_issue      - hold issue of new multicycle ops
//            fifo_count       - current FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       wen_au,
  input  logic [4:0]                 reg_rd_au,
  input  logic [WORD_W-1:0]          wdata_au,
  input  logic                       mu_valid,
  input  logic [4:0]                 mu_rd,
  input  logic [WORD_W-1:0]          mu_wdata,
  output logic                       mu_ready,
  output logic                       rf_wen,
  output logic [4:0]                 rf_rd,
  output logic [WORD_W-1:0]          rf_wdata,
  output logic                       stall_issue,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_STALL = c_CNT_W'(DEPTH - 1);

  // FIFO storage (data path only, no reset needed)
  logic [4:0]        mem_rd_q   [DEPTH];
  logic [WORD_W-1:0] mem_data_q [DEPTH];

  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0] count_q,  count_d;

  logic              rf_wen_q,   rf_wen_d;
  logic [4:0]        rf_rd_q,    rf_rd_d;
  logic [WORD_W-1:0] rf_wdata_q, rf_wdata_d;

  logic w_au_go;
  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_bypass;
  logic w_enq;

  // Handshake depends only on registered occupancy: a pop in the same cycle
  // never frees a slot for a push while full.
  assign w_ready  = (count_q != c_FULL);
  assign w_au_go  = wen_au && (reg_rd_au != 5'd0);
  assign w_push   = mu_valid && w_ready;
  assign w_pop    = !w_au_go && (count_q != '0);
  assign w_bypass = !w_au_go && (count_q == '0) && w_push && (mu_rd != 5'd0);
  // rd==0 results complete the handshake but are dropped here
  assign w_enq    = w_push && (mu_rd != 5'd0) && !w_bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_enq) begin
      wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
    end
    count_d = count_q + {{(c_CNT_W-1){1'b0}}, w_enq} - {{(c_CNT_W-1){1'b0}}, w_pop};
  end

  // Next write-port value: AU, then FIFO head, then bypass, else idle with
  // address/data holding their last values.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (w_au_go) begin
      rf_wen_d   = 1'b1;
      rf_rd_d    = reg_rd_au;
      rf_wdata_d = wdata_au;
    end else if (w_pop) begin
      rf_wen_d   = 1'b1;
      rf_rd_d    = mem_rd_q[rd_ptr_q];
      rf_wdata_d = mem_data_q[rd_ptr_q];
    end else if (w_bypass) begin
      rf_wen_d   = 1'b1;
      rf_rd_d    = mu_rd;
      rf_wdata_d = mu_wdata;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rf_wen_q   <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rf_wen_q   <= rf_wen_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_enq) begin
      mem_rd_q[wr_ptr_q]   <= mu_rd;
      mem_data_q[wr_ptr_q] <= mu_wdata;
    end
  end

  assign mu_ready    = w_ready;
  assign stall_issue = (count_q >= c_STALL);
  assign fifo_count  = count_q;
  assign rf_wen      = rf_wen_q;
  assign rf_rd       = rf_rd_q;
  assign rf_wdata    = rf_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Self-checking bench for wb_arbiter. A queue-based reference model
//            predicts each cycle's write-port value; predictions are queued
//            when stimulus is driven and compared after the clock edge. A
//            hand-written vector table and directed sequences cover the
//            bypass, contention, full-with-pop and async-reset corners.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        wen_au;
  logic [4:0]  reg_rd_au;
  logic [31:0] wdata_au;
  logic        mu_valid;
  logic [4:0]  mu_rd;
  logic [31:0] mu_wdata;
  logic        mu_ready;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        stall_issue;
  logic [2:0]  fifo_count;

  wb_arbiter #(.DEPTH(DEPTH), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .wen_au(wen_au), .reg_rd_au(reg_rd_au), .wdata_au(wdata_au),
    .mu_valid(mu_valid), .mu_rd(mu_rd), .mu_wdata(mu_wdata),
    .mu_ready(mu_ready),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .stall_issue(stall_issue), .fifo_count(fifo_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
  } out_t;

  typedef struct {
    logic        aw;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        e_wen;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    int          e_cnt;
  } vec_t;

  int total = 0;
  int bad   = 0;

  ent_t        mq[$];
  out_t        exp_q[$];
  logic [4:0]  last_rd   = 5'd0;
  logic [31:0] last_data = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check handshake/status, predict, clock,
  // then compare the write port against the oldest prediction.
  task automatic step(input logic aw, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      output logic acc);
    logic au_go, rdy, push, byp;
    out_t e, o;
    ent_t h;
    @(negedge CLK);
    wen_au = aw; reg_rd_au = ard; wdata_au = ad;
    mu_valid = mv; mu_rd = mrd; mu_wdata = md;
    #1;
    chk("mu_ready",    {63'd0, mu_ready},    {63'd0, (mq.size() != DEPTH)});
    chk("stall_issue", {63'd0, stall_issue}, {63'd0, (mq.size() >= DEPTH - 1)});
    chk("fifo_count",  64'(fifo_count),      64'(mq.size()));
    au_go = aw && (ard != 5'd0);
    rdy   = (mq.size() != DEPTH);
    push  = mv && rdy;
    byp   = 1'b0;
    if (au_go) begin
      e = {1'b1, ard, ad};
    end else if (mq.size() != 0) begin
      h = mq.pop_front();
      e = {1'b1, h.rd, h.data};
    end else if (push && (mrd != 5'd0)) begin
      e = {1'b1, mrd, md};
      byp = 1'b1;
    end else begin
      e = {1'b0, last_rd, last_data};
    end
    if (push && (mrd != 5'd0) && !byp) mq.push_back({mrd, md});
    last_rd   = e.rd;
    last_data = e.data;
    exp_q.push_back(e);
    acc = push;
    @(posedge CLK);
    #1;
    o = exp_q.pop_front();
    chk("rf_wen",   {63'd0, rf_wen}, {63'd0, o.wen});
    chk("rf_rd",    64'(rf_rd),      64'(o.rd));
    chk("rf_wdata", 64'(rf_wdata),   64'(o.data));
  endtask

  task automatic idle(output logic acc);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    logic acc;
    int   n;

    // expected values are for the cycle after each vector is applied
    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hDEADBEEF, 0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd5, 32'hDEADBEEF, 0};
    tbl[2] = '{1'b1, 5'd0, 32'h1111,     1'b1, 5'd0, 32'h2222, 1'b0, 5'd5, 32'hDEADBEEF, 0};
    tbl[3] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h12,   1'b1, 5'd7, 32'h12,       0};
    tbl[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd7, 32'h12,       0};
    tbl[5] = '{1'b1, 5'd3, 32'hA,        1'b1, 5'd9, 32'hB,    1'b1, 5'd3, 32'hA,        1};
    tbl[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'hB,        0};
    tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd9, 32'hB,        0};

    nRST = 1'b0;
    wen_au = 1'b0; reg_rd_au = 5'd0; wdata_au = 32'd0;
    mu_valid = 1'b0; mu_rd = 5'd0; mu_wdata = 32'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("rst_rf_wen",   {63'd0, rf_wen},      64'd0);
    chk("rst_rf_rd",    64'(rf_rd),           64'd0);
    chk("rst_rf_wdata", 64'(rf_wdata),        64'd0);
    chk("rst_count",    64'(fifo_count),      64'd0);
    chk("rst_ready",    {63'd0, mu_ready},    64'd1);
    chk("rst_stall",    {63'd0, stall_issue}, 64'd0);

    // vector table
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].aw, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd, tbl[i].md, acc);
      chk($sformatf("vec%0d_wen", i),   {63'd0, rf_wen}, {63'd0, tbl[i].e_wen});
      chk($sformatf("vec%0d_rd", i),    64'(rf_rd),      64'(tbl[i].e_rd));
      chk($sformatf("vec%0d_data", i),  64'(rf_wdata),   64'(tbl[i].e_data));
      chk($sformatf("vec%0d_count", i), 64'(fifo_count), 64'(tbl[i].e_cnt));
    end

    // contention: AU busy for 6 cycles while MU offers rd 1..4
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 5'(10 + i), 32'hA000 + i, (n < 4), 5'(n + 1), 32'h100 + n, acc);
      if (acc) n++;
      if (i == 2) begin
        chk("cont_stall",  {63'd0, stall_issue}, 64'd1);
        chk("cont_count3", 64'(fifo_count),      64'd3);
      end
      if (i == 3) chk("cont_ready_low", {63'd0, mu_ready}, 64'd0);
    end
    for (int k = 0; k < 4; k++) begin
      idle(acc);
      chk($sformatf("cont_drain%0d_rd", k), 64'(rf_rd), 64'(k + 1));
      chk($sformatf("cont_drain%0d_wen", k), {63'd0, rf_wen}, 64'd1);
    end
    chk("cont_empty", 64'(fifo_count), 64'd0);

    // full with simultaneous pop: no push that cycle, accepted the next
    for (int i = 0; i < DEPTH; i++) step(1'b1, 5'd30, 32'hF0 + i, 1'b1, 5'(i + 1), 32'h200 + i, acc);
    chk("full_count", 64'(fifo_count), 64'(DEPTH));
    chk("full_ready", {63'd0, mu_ready}, 64'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h20, acc);
    chk("full_pop_rd",    64'(rf_rd),      64'd1);
    chk("full_pop_count", 64'(fifo_count), 64'(DEPTH - 1));
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h20, acc);
    chk("full_next_rd",    64'(rf_rd),      64'd2);
    chk("full_next_count", 64'(fifo_count), 64'(DEPTH - 1));
    for (int i = 0; i < 8 && mq.size() != 0; i++) idle(acc);
    chk("full_drained", 64'(fifo_count), 64'd0);

    // randomized traffic, many pointer wraps
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), $urandom, acc);
    end
    for (int i = 0; i < 8 && mq.size() != 0; i++) idle(acc);

    // async reset mid-drain with three entries queued
    for (int i = 0; i < DEPTH; i++) step(1'b1, 5'd31, 32'hE0 + i, 1'b1, 5'(i + 11), 32'h300 + i, acc);
    idle(acc);
    chk("pre_rst_count", 64'(fifo_count), 64'd3);
    chk("pre_rst_wen",   {63'd0, rf_wen}, 64'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_wen",   {63'd0, rf_wen},      64'd0);
    chk("arst_rd",    64'(rf_rd),           64'd0);
    chk("arst_data",  64'(rf_wdata),        64'd0);
    chk("arst_count", 64'(fifo_count),      64'd0);
    chk("arst_ready", {63'd0, mu_ready},    64'd1);
    chk("arst_stall", {63'd0, stall_issue}, 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    mq.delete();
    exp_q.delete();
    last_rd = 5'd0;
    last_data = 32'd0;
    for (int i = 0; i < 6; i++) begin
      idle(acc);
      chk("post_rst_no_write", {63'd0, rf_wen}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Consumer end of the arithmetic-unit result interface. Takes the arithmetic unit's result triple (wen_au, reg_rd_au, wdata_au) and the multicycle unit's (mul/div) results, and merges them onto the single register-file write port.
- Arithmetic-unit results cannot be back-pressured, so they always win. Multicycle results are buffered in a small FIFO and drained in idle slots.
- Sits between the execute units and the register file. It raises an issue stall when its buffer is nearly full.

Parameters:
- DEPTH, 4, multicycle-result FIFO entries; power of two, minimum 2.
- WORD_W, 32, data width (rv32i word_t).

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- wen_au  input  1  arithmetic unit result valid this cycle
- reg_rd_au  input  5  arithmetic unit destination register
- wdata_au  input  WORD_W  arithmetic unit result
- mu_valid  input  1  multicycle unit result valid
- mu_rd  input  5  multicycle unit destination register
- mu_wdata  input  WORD_W  multicycle unit result
- mu_ready  output  1  buffer can accept a multicycle result this cycle
- rf_wen  output  1  register-file write enable (registered)
- rf_rd  output  5  register-file write address (registered)
- rf_wdata  output  WORD_W  register-file write data (registered)
- stall_issue  output  1  hold issue of new multicycle ops
- fifo_count  output  $clog2(DEPTH+1)  current occupancy, for debug and verification

Behaviour:
- Reset (nRST low, asynchronous): rf_wen=0, rf_rd=0, rf_wdata=0, FIFO read/write pointers and count = 0. Consequently mu_ready=1 and stall_issue=0. Reset asserted mid-drain discards all queued entries with no write issued.
- Effective AU write: au_go = wen_au && (reg_rd_au != 0).
- MU push: push = mu_valid && mu_ready. mu_ready = (count != DEPTH), combinational from registered count only. There is no push-while-full, even if a pop occurs in the same cycle.
- Entries with mu_rd == 0 are accepted (handshake completes) but are not enqueued.
- Pop: pop = !au_go && (count != 0). The head entry drives the next rf_* values.
- Bypass: if !au_go, count == 0 and push of a nonzero rd occurs, the entry is written out next cycle directly and not enqueued (count unchanged).
- Output select for the next cycle, in priority order:
  1. au_go → AU triple.
  2. pop → FIFO head.
  3. bypass → MU triple.
  4. Otherwise rf_wen=0, with rf_rd and rf_wdata holding their previous values.
- Latency: AU result appears on rf_* exactly 1 cycle after wen_au. An MU result takes 1 cycle when bypassed, otherwise 1 + (number of AU-occupied cycles and older entries ahead of it).
- Ordering: MU results retire in acceptance order. No reordering relative to each other.
- Count update: count_next = count + (enqueue) − (pop). Simultaneous enqueue and pop leaves count unchanged, with both pointers advancing. Pointers wrap modulo DEPTH.
- stall_issue = (count >= DEPTH−1), registered-count based. This gives one entry of slack for an op already in flight.
- WAW between AU and MU for the same rd is prevented by the issue scoreboard. This block performs no rd comparison.
- Sustained au_go starves the FIFO indefinitely. That is legal: stall_issue bounds occupancy.

Test Plan:
- Reset release, AU write wen_au=1, rd=5, data=0xDEADBEEF → next cycle rf_wen=1, rf_rd=5, rf_wdata=0xDEADBEEF; following idle cycle rf_wen=0.
- AU write with rd=0 and MU push with rd=0 → rf_wen stays 0; MU handshake completes (mu_ready=1) and fifo_count stays 0.
- Bypass: empty FIFO, AU idle, MU push rd=7, data=0x12 → next cycle rf_wen=1, rf_rd=7, rf_wdata=0x12; fifo_count stays 0.
- Contention: AU writes every cycle for 6 cycles while MU pushes rd=1..4 → mu_ready drops after the 4th push and stall_issue asserts at count=3. After AU goes idle, rd 1,2,3,4 retire on 4 consecutive cycles in order, and count returns to 0.
- Full plus simultaneous pop: count=DEPTH, AU idle, mu_valid=1 → no push that cycle (mu_ready=0); pop drains head; push is accepted next cycle, and count wraps pointers correctly over 3×DEPTH transactions.
- Asynchronous reset asserted with count=3 mid-drain → all outputs cleared immediately with no clock; after release, no stale entry is ever written.
